// File: rtl/fft_pkg.sv
// Shared types and default sizes for the FFT job arbiter slice.
package fft_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned FFT_POINTS_DEF = 64;
  localparam int unsigned ADDR_WIDTH_DEF = $clog2(FFT_POINTS_DEF);
  localparam int unsigned TIMEOUT_DEF    = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/fft_job_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: pointer channel wins ties; pointer moves past the last served channel.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last_ch,
  output logic [1:0] gnt_c
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ~last_ch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  // Pointer channel first, then the other one
  always_comb begin
    gnt_c = 2'b00;
    if (req[ptr_q])       gnt_c = ptr_q ? 2'b10 : 2'b01;
    else if (req[~ptr_q]) gnt_c = ptr_q ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/fft_job_arbiter.sv
// Shares one pipelined FFT core between two channels: grant, stream-in, start, route results back.
module fft_job_arbiter
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FFT_POINTS = FFT_POINTS_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(FFT_POINTS),
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req,
  output logic [1:0]              gnt,
  input  logic [1:0]              s_valid,
  output logic [1:0]              s_ready,
  input  logic [2*DATA_WIDTH-1:0] s_real,
  input  logic [2*DATA_WIDTH-1:0] s_imag,
  output logic [1:0]              m_valid,
  output logic [DATA_WIDTH-1:0]   m_real,
  output logic [DATA_WIDTH-1:0]   m_imag,
  output logic                    job_done,
  output logic                    job_abort,
  output logic                    fft_start,
  output logic                    fft_data_valid,
  output logic [DATA_WIDTH-1:0]   fft_data_real,
  output logic [DATA_WIDTH-1:0]   fft_data_imag,
  input  logic                    fft_busy,
  input  logic                    fft_done,
  input  logic                    fft_out_valid,
  input  logic [DATA_WIDTH-1:0]   fft_out_real,
  input  logic [DATA_WIDTH-1:0]   fft_out_imag
);

  localparam int unsigned CW   = ADDR_WIDTH + 1;
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   PTS      = CW'(FFT_POINTS);
  localparam logic [CW-1:0]   PTS_LAST = CW'(FFT_POINTS - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [1:0]            gnt_q, gnt_d;
  logic                  ch_q, ch_d;
  logic [CW-1:0]         in_cnt_q, in_cnt_d;
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic [1:0]            m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_real_q, m_real_d, m_imag_q, m_imag_d;
  logic                  job_done_q, job_done_d;
  logic                  job_abort_q, job_abort_d;
  logic                  fft_start_q, fft_start_d;

  logic [1:0]            arb_gnt_c;
  logic                  arb_advance_c;
  logic [1:0]            s_ready_c;
  logic                  xfer_c;
  logic [DATA_WIDTH-1:0] sel_real_c, sel_imag_c;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (arb_advance_c),
    .last_ch (ch_q),
    .gnt_c   (arb_gnt_c)
  );

  assign sel_real_c = ch_q ? s_real[2*DATA_WIDTH-1:DATA_WIDTH] : s_real[DATA_WIDTH-1:0];
  assign sel_imag_c = ch_q ? s_imag[2*DATA_WIDTH-1:DATA_WIDTH] : s_imag[DATA_WIDTH-1:0];

  // Job sequencing, counters and watchdog
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ch_d          = ch_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    m_valid_d     = 2'b00;
    m_real_d      = m_real_q;
    m_imag_d      = m_imag_q;
    job_done_d    = 1'b0;
    job_abort_d   = 1'b0;
    fft_start_d   = 1'b0;
    arb_advance_c = 1'b0;
    s_ready_c     = 2'b00;
    xfer_c        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if ((|req) && !fft_busy) begin
          gnt_d   = arb_gnt_c;
          ch_d    = arb_gnt_c[1];
          state_d = ST_START;
        end
      end
      ST_START: begin
        fft_start_d = 1'b1;
        in_cnt_d    = '0;
        out_cnt_d   = '0;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        s_ready_c[ch_q] = (in_cnt_q < PTS);
        xfer_c          = s_valid[ch_q] && (in_cnt_q < PTS);
        if (xfer_c) begin
          in_cnt_d = in_cnt_q + CW'(1);
          if (in_cnt_q == PTS_LAST) begin
            wd_cnt_d = '0;
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT, ST_DRAIN: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (state_q == ST_WAIT && (fft_done || fft_out_valid)) state_d = ST_DRAIN;
        if (fft_out_valid) begin
          m_valid_d[ch_q] = 1'b1;
          m_real_d        = fft_out_real;
          m_imag_d        = fft_out_imag;
          out_cnt_d       = out_cnt_q + CW'(1);
        end
        // Normal completion takes precedence over a coincident timeout
        if (fft_out_valid && out_cnt_q == PTS_LAST) begin
          job_done_d    = 1'b1;
          gnt_d         = 2'b00;
          arb_advance_c = 1'b1;
          state_d       = ST_IDLE;
        end else if (wd_cnt_q == WD_LAST) begin
          job_abort_d   = 1'b1;
          gnt_d         = 2'b00;
          arb_advance_c = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      ch_q        <= 1'b0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      wd_cnt_q    <= '0;
      m_valid_q   <= 2'b00;
      m_real_q    <= '0;
      m_imag_q    <= '0;
      job_done_q  <= 1'b0;
      job_abort_q <= 1'b0;
      fft_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ch_q        <= ch_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      m_valid_q   <= m_valid_d;
      m_real_q    <= m_real_d;
      m_imag_q    <= m_imag_d;
      job_done_q  <= job_done_d;
      job_abort_q <= job_abort_d;
      fft_start_q <= fft_start_d;
    end
  end

  // Input path to the core is zero-latency; everything else is registered
  assign s_ready        = s_ready_c;
  assign fft_data_valid = xfer_c;
  assign fft_data_real  = xfer_c ? sel_real_c : '0;
  assign fft_data_imag  = xfer_c ? sel_imag_c : '0;
  assign gnt            = gnt_q;
  assign m_valid        = m_valid_q;
  assign m_real         = m_real_q;
  assign m_imag         = m_imag_q;
  assign job_done       = job_done_q;
  assign job_abort      = job_abort_q;
  assign fft_start      = fft_start_q;

endmodule

// File: tb/tb_fft_job_arbiter.sv
// Directed bench for fft_job_arbiter with a behavioural FFT core and a result scoreboard.
module tb_fft_job_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned NP = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    req, s_valid;
  logic [2*DW-1:0] s_real, s_imag;
  logic          fft_busy, fft_done, fft_out_valid;
  logic [DW-1:0] fft_out_real, fft_out_imag;

  logic [1:0]    gnt, s_ready, m_valid;
  logic [DW-1:0] m_real, m_imag, fft_data_real, fft_data_imag;
  logic          job_done, job_abort, fft_start, fft_data_valid;

  logic [1:0]    w_gnt, w_s_ready, w_m_valid;
  logic [DW-1:0] w_m_real, w_m_imag, w_fft_data_real, w_fft_data_imag;
  logic          w_job_done, w_job_abort, w_fft_start, w_fft_data_valid;

  fft_job_arbiter #(.DATA_WIDTH(DW), .FFT_POINTS(NP), .ADDR_WIDTH(6), .TIMEOUT(4096)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_imag(s_imag), .m_valid(m_valid), .m_real(m_real), .m_imag(m_imag),
    .job_done(job_done), .job_abort(job_abort), .fft_start(fft_start),
    .fft_data_valid(fft_data_valid), .fft_data_real(fft_data_real), .fft_data_imag(fft_data_imag),
    .fft_busy(fft_busy), .fft_done(fft_done), .fft_out_valid(fft_out_valid),
    .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag)
  );

  // Short-watchdog instance sharing all inputs; only examined in the hang scenario
  fft_job_arbiter #(.DATA_WIDTH(DW), .FFT_POINTS(NP), .ADDR_WIDTH(6), .TIMEOUT(16)) u_wd (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(w_gnt), .s_valid(s_valid), .s_ready(w_s_ready),
    .s_real(s_real), .s_imag(s_imag), .m_valid(w_m_valid), .m_real(w_m_real), .m_imag(w_m_imag),
    .job_done(w_job_done), .job_abort(w_job_abort), .fft_start(w_fft_start),
    .fft_data_valid(w_fft_data_valid), .fft_data_real(w_fft_data_real),
    .fft_data_imag(w_fft_data_imag), .fft_busy(fft_busy), .fft_done(fft_done),
    .fft_out_valid(fft_out_valid), .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int n_start = 0, n_dv = 0, n_done = 0, n_abort = 0, n_wabort = 0;
  int n_mv [2] = '{0, 0};
  int t_start = 0, t_wabort = 0, last_t_req = 0, last_xfer = 0;
  int sready_other = 0, w_gnt_cnt = 0, exp_ch = 0;
  logic [1:0]  last_gnt = 2'b00;
  int          grant_log [$];
  logic [31:0] exp_q [$];
  logic [31:0] core_in [$];
  bit core_run = 0, core_hang = 0;
  int core_wait = 0, core_sent = 0, core_emit_n = 0;

  function automatic logic [31:0] xform(input logic [31:0] x);
    return {x[31:16] + 16'h1234, x[15:0] ^ 16'h00ff};
  endfunction

  function automatic logic [31:0] sample(input int ch, input int i);
    return {16'(32'h0100 + ch * 32'h1000 + i * 3), 16'(32'hA000 - i * 7)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {54'd0, gnt, s_ready, m_valid, job_done, job_abort, fft_start, fft_data_valid}, 0);
    chk({tag, "_data"}, {m_real, m_imag, fft_data_real, fft_data_imag}, 0);
    chk({tag, "_wd_ctrl"}, {54'd0, w_gnt, w_s_ready, w_m_valid, w_job_done, w_job_abort,
                            w_fft_start, w_fft_data_valid}, 0);
    chk({tag, "_wd_data"}, {w_m_real, w_m_imag, w_fft_data_real, w_fft_data_imag}, 0);
  endtask

  // One clock: monitor/scoreboard at negedge, then core model drive just after posedge
  task automatic tick();
    @(negedge clk);
    if (fft_start) begin n_start++; t_start = cyc; fft_busy = 1'b1; end
    if (fft_data_valid) begin
      n_dv++;
      core_in.push_back({fft_data_real, fft_data_imag});
      if (core_in.size() == NP && !core_hang) begin
        core_run = 1; core_wait = 3; core_sent = 0;
      end
    end
    if (s_ready[1 - exp_ch]) sready_other++;
    if (gnt != 2'b00 && last_gnt == 2'b00) grant_log.push_back(gnt[1] ? 1 : 0);
    last_gnt = gnt;
    if (w_gnt != 2'b00) w_gnt_cnt++;
    if (m_valid != 2'b00) begin
      n_mv[exp_ch]++;
      chk("m_valid_route", {62'd0, m_valid}, 64'(2'b01 << exp_ch));
      chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("sb_result", {32'd0, m_real, m_imag}, {32'd0, exp_q.pop_front()});
    end
    if (job_done) n_done++;
    if (job_abort) n_abort++;
    if (w_job_abort) begin n_wabort++; t_wabort = cyc; end
    cyc++;
    @(posedge clk);
    #1;
    fft_out_valid = 1'b0;
    fft_done      = 1'b0;
    if (core_run) begin
      if (core_wait > 0) core_wait--;
      else if (core_sent < core_emit_n) begin
        fft_out_valid = 1'b1;
        {fft_out_real, fft_out_imag} = (core_sent < NP) ? xform(core_in[core_sent])
                                                        : (32'hDEAD0000 | 32'(core_sent));
        core_sent++;
      end else begin
        fft_done = 1'b1; fft_busy = 1'b0; core_run = 0;
      end
    end
  endtask

  // Request a job on ch, wait for grant, stream n_samp samples (alternating gaps if gap)
  task automatic run_job(input int ch, input bit gap, input int emit_n, input int n_samp);
    int idx, guard;
    logic [31:0] smp;
    logic want;
    core_in.delete(); core_run = 0; core_emit_n = emit_n; exp_ch = ch; sready_other = 0;
    req[ch] = 1'b1; last_t_req = cyc;
    guard = 0;
    while (!gnt[ch] && guard < 200) begin tick(); guard++; end
    chk("gnt_wait", {63'd0, gnt[ch]}, 1);
    req[ch] = 1'b0;
    idx = 0; guard = 0;
    while (idx < n_samp && guard < 1000) begin
      smp  = sample(ch, idx);
      want = gap ? ((guard % 2) == 0) : 1'b1;
      s_valid[ch] = want;
      s_real[ch*DW +: DW] = smp[31:16];
      s_imag[ch*DW +: DW] = smp[15:0];
      #1;
      if (s_ready[ch]) begin
        chk("dv_mirror", {63'd0, fft_data_valid}, {63'd0, want});
        if (want) begin
          chk("fft_data", {32'd0, fft_data_real, fft_data_imag}, {32'd0, smp});
          exp_q.push_back(xform(smp));
          idx++;
          last_xfer = cyc;
        end
      end
      tick();
      guard++;
    end
    chk("load_count", idx, n_samp);
    if (n_samp == NP) s_valid = 2'b00;
  endtask

  task automatic wait_done(input int d0);
    int g;
    g = 0;
    while (n_done == d0 && g < 400) begin tick(); g++; end
    chk("done_wait", 64'(n_done > d0), 1);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    s_valid = 2'b00; req = 2'b00; fft_busy = 1'b0; fft_out_valid = 1'b0; fft_done = 1'b0;
    core_run = 0; core_hang = 0; exp_q.delete(); core_in.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int s0, dv0, d0, mv0, g, code;
    rst_n = 1'b0; req = 2'b00; s_valid = 2'b00; s_real = '0; s_imag = '0;
    fft_busy = 1'b0; fft_done = 1'b0; fft_out_valid = 1'b0; fft_out_real = '0; fft_out_imag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Hang: core never responds; short-watchdog instance must abort and stay off while busy
    core_hang = 1;
    run_job(0, 1'b0, 0, NP);
    g = 0;
    while (n_wabort == 0 && g < 100) begin tick(); g++; end
    chk("wd_abort_latency", t_wabort - last_xfer, 17);
    w_gnt_cnt = 0;
    req = 2'b01;
    repeat (20) tick();
    chk("wd_no_regrant_busy", w_gnt_cnt, 0);
    chk("wd_abort_once", n_wabort, 1);
    chk("main_no_abort", n_abort, 0);
    apply_reset("reset_after_hang");

    // Single job on channel 0
    s0 = n_start; dv0 = n_dv; d0 = n_done; mv0 = n_mv[0];
    run_job(0, 1'b0, NP, NP);
    chk("start_latency", t_start - last_t_req, 2);
    wait_done(d0);
    repeat (8) tick();
    chk("single_start_once", n_start - s0, 1);
    chk("single_dv_cycles", n_dv - dv0, NP);
    chk("single_mv_beats", n_mv[0] - mv0, NP);
    chk("single_done_once", n_done - d0, 1);
    chk("single_gnt_clear", {62'd0, gnt}, 0);
    chk("single_sb_empty", exp_q.size(), 0);
    chk("single_other_ready", sready_other, 0);

    // Overrun: core emits 70 results, only 64 forwarded
    d0 = n_done; mv0 = n_mv[0];
    run_job(0, 1'b0, 70, NP);
    wait_done(d0);
    repeat (12) tick();
    chk("overrun_mv_beats", n_mv[0] - mv0, NP);
    chk("overrun_done_once", n_done - d0, 1);
    chk("overrun_sb_empty", exp_q.size(), 0);

    // Input gaps on channel 1
    dv0 = n_dv; d0 = n_done; mv0 = n_mv[1];
    run_job(1, 1'b1, NP, NP);
    chk("gap_dv_cycles", n_dv - dv0, NP);
    chk("gap_sready0_low", sready_other, 0);
    wait_done(d0);
    repeat (4) tick();
    chk("gap_mv_beats", n_mv[1] - mv0, NP);

    // Contention: both request, expect grant order 0,1,0
    grant_log.delete();
    req = 2'b11;
    d0 = n_done;
    run_job(0, 1'b0, NP, NP);
    chk("cont_ch1_held", {63'd0, req[1]}, 1);
    wait_done(d0);
    req[0] = 1'b1;
    d0 = n_done;
    run_job(1, 1'b0, NP, NP);
    wait_done(d0);
    d0 = n_done;
    run_job(0, 1'b0, NP, NP);
    wait_done(d0);
    repeat (4) tick();
    chk("cont_grants", grant_log.size(), 3);
    code = (grant_log.size() == 3) ? grant_log[0] * 100 + grant_log[1] * 10 + grant_log[2] : -1;
    chk("cont_order", code, 10);

    // Reset mid-LOAD, then a clean restart
    run_job(0, 1'b0, NP, 10);
    apply_reset("reset_mid_load");
    s0 = n_start; dv0 = n_dv; d0 = n_done; mv0 = n_mv[0];
    run_job(0, 1'b0, NP, NP);
    chk("restart_latency", t_start - last_t_req, 2);
    wait_done(d0);
    repeat (4) tick();
    chk("restart_start_once", n_start - s0, 1);
    chk("restart_dv_cycles", n_dv - dv0, NP);
    chk("restart_mv_beats", n_mv[0] - mv0, NP);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/fft_job_arbiter.md
Name: fft_job_arbiter

Overview:
- Shares one fft_top_pipelined instance between two requester channels.
- Each channel requests a job, gets a grant, and streams FFT_POINTS complex samples in; the arbiter starts the core and routes the core's result stream back to the granted channel.
- Round-robin arbitration between jobs; a watchdog aborts a job if the core hangs.
- Sits between the board/host glue and the FFT core, replacing the single-user demo sequencer.

Parameters:
- DATA_WIDTH, 16, sample component width (two's complement).
- FFT_POINTS, 64, samples per job in and out.
- ADDR_WIDTH, 6, sample counter width; clog2(FFT_POINTS).
- TIMEOUT, 4096, maximum cycles in WAIT plus DRAIN before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req  in  2  per-channel job request; level-sensitive, held until grant
- gnt  out  2  one-hot grant; high for the whole job
- s_valid  in  2  per-channel input sample valid
- s_ready  out  2  per-channel input sample ready
- s_real  in  2*DATA_WIDTH  per-channel input real part; channel i uses bits [i*DW +: DW]
- s_imag  in  2*DATA_WIDTH  per-channel input imaginary part; same packing as s_real
- m_valid  out  2  result valid, routed to the granted channel; no backpressure
- m_real  out  DATA_WIDTH  result real part; shared bus
- m_imag  out  DATA_WIDTH  result imaginary part; shared bus
- job_done  out  1  one-cycle pulse when a job completes normally
- job_abort  out  1  one-cycle pulse when the watchdog fires
- fft_start  out  1  to core: start pulse
- fft_data_valid  out  1  to core: input sample valid
- fft_data_real  out  DATA_WIDTH  to core: input sample real part
- fft_data_imag  out  DATA_WIDTH  to core: input sample imaginary part
- fft_busy  in  1  from core
- fft_done  in  1  from core
- fft_out_valid  in  1  from core
- fft_out_real  in  DATA_WIDTH  from core
- fft_out_imag  in  DATA_WIDTH  from core

Behaviour:
- Reset values (all outputs 0):
  - gnt, s_ready, m_valid, job_done, job_abort, fft_start, fft_data_valid: 0
  - m_real, m_imag, fft_data_real, fft_data_imag: 0
  - State is IDLE, priority pointer is channel 0, all counters are 0.
- FSM states are IDLE, START, LOAD, WAIT, DRAIN.
- IDLE:
  - Acts only if req != 0 and fft_busy == 0.
  - Grant the requesting channel nearest the priority pointer; if both request, the pointer wins.
  - Register gnt, then go to START.
- START:
  - fft_start = 1 for exactly one cycle.
  - in_cnt and out_cnt clear to 0; go to LOAD.
- LOAD:
  - s_ready[g] = 1 while in_cnt < FFT_POINTS; s_ready is 0 for the other channel.
  - Each cycle with s_valid[g] && s_ready[g]: drive fft_data_valid = 1 with the sample combinationally (zero latency), and in_cnt increments.
  - After the FFT_POINTS-th transfer, s_ready drops the next cycle and the FSM goes to WAIT.
  - Input gaps (s_valid low) are allowed; fft_data_valid follows s_valid.
- WAIT:
  - Go to DRAIN on fft_done or on the first fft_out_valid.
  - An fft_out_valid in this state is already forwarded and counted.
- Output routing (WAIT and DRAIN):
  - m_valid[g] = fft_out_valid, registered with 1-cycle latency; m_real/m_imag registered alongside.
  - m_valid of the non-granted channel stays 0.
  - out_cnt increments per fft_out_valid.
- DRAIN completion:
  - When out_cnt reaches FFT_POINTS: job_done pulses, gnt clears, the pointer moves to the other channel, and the FSM returns to IDLE.
  - Extra fft_out_valid beats after that are dropped (m_valid stays 0).
- Watchdog:
  - wd_cnt clears on entry to WAIT and increments each cycle in WAIT/DRAIN.
  - At TIMEOUT-1: job_abort pulses, gnt clears, the pointer rotates, and the FSM returns to IDLE.
  - The arbiter does not reset the core; a core still busy blocks the next grant.
- Request handling:
  - Deasserting req mid-job is ignored; the job runs to completion.
  - Re-asserting req during a job is not granted until IDLE.
  - Both channels requesting in the same cycle: the pointer channel wins; the loser is granted after the winner's job ends.
- Asynchronous reset mid-job returns everything to reset values immediately.
- Counters are ADDR_WIDTH+1 bits so that the value FFT_POINTS is representable.

Decomposition:
- Shared package fft_pkg holds:
  - the state encoding localparams
  - DATA_WIDTH/FFT_POINTS defaults
  - ADDR_WIDTH = clog2(FFT_POINTS)
- One sub-module, rr_arbiter2: 2-way round-robin grant logic with a pointer-update input.
- The FSM, counters, watchdog and muxing stay in the top.

Test Plan:
- Single job: req=01, 64 samples back-to-back.
  - fft_start pulses exactly once, 2 cycles after req.
  - fft_data_valid is high for exactly 64 cycles.
  - With the core model emitting 64 results, m_valid[0] rises 64 times; job_done pulses once; gnt=00 afterwards.
- Contention: req=11 from reset.
  - Channel 0 job runs, then channel 1.
  - A third job on channel 0 is served only after channel 1 finishes; grant order is 0,1,0.
- Input gaps: s_valid[1] toggles 1/0 during LOAD.
  - fft_data_valid mirrors the toggling; exactly 64 transfers occur.
  - s_ready[0] stays 0 throughout.
- Hang: the core model never asserts done or out_valid; TIMEOUT=16.
  - job_abort pulses 16 cycles after WAIT entry; FSM returns to IDLE.
  - With fft_busy still 1, no new grant is issued.
- Overrun: the core model emits 70 results.
  - Exactly 64 m_valid beats reach the granted channel; job_done pulses once; the other 6 beats are dropped.
- Reset mid-LOAD: rst_n pulsed low after 10 samples.
  - All outputs are 0 immediately; the next req restarts with in_cnt=0 and a fresh fft_start.
